branch_predictor_ram_mw: RTL and testbench

- Multi-way, parametrised successor to the single-way branch predictor RAM.
- Holds NUM_WAYS tag/target entries per index, with per-way write enables.
- Provides synthesisable write-first bypass, so no simulation-only forcing is needed.
- Includes a hardware clear FSM that zeroes every entry after reset or on a flush request.
- Sits between fetch (reads) and branch unit miss/update logic (writes).

---
 rtl/taiga_types.sv | 9 +
 rtl/bp_ram_bank.sv | 28 ++
 rtl/branch_predictor_ram_mw.sv | 127 ++++++++++++
 tb/tb_branch_predictor_ram_mw.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/taiga_types.sv
// Shared types for the multi-way branch predictor RAM.
package taiga_types;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } bp_ram_state_t;

endpackage

// File: rtl/bp_ram_bank.sv
// One way of predictor storage: simple dual-port RAM with read-first behaviour and a registered read.
module bp_ram_bank #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 512
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the output register is reset; the array itself is zeroed by the clear FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/branch_predictor_ram_mw.sv
// Multi-way branch predictor RAM with hardware clear FSM and write-first bypass.
// Optional per-way even parity is enabled with `define BP_RAM_PARITY_EN.
module branch_predictor_ram_mw
   import taiga_types::*;
#(
   parameter int DATA_WIDTH = 20,
   parameter int DEPTH      = 512,
   parameter int NUM_WAYS   = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear_req,
   output logic                           ready,
   input  logic [$clog2(DEPTH)-1:0]       write_addr,
   input  logic                           write_en,
   input  logic [NUM_WAYS-1:0]            write_way,
   input  logic [DATA_WIDTH-1:0]          write_data,
   input  logic [$clog2(DEPTH)-1:0]       read_addr,
   input  logic                           read_en,
   output logic [NUM_WAYS*DATA_WIDTH-1:0] read_data,
   output logic                           read_valid,
   output logic [NUM_WAYS-1:0]            read_parity_err
);

   localparam int AW = $clog2(DEPTH);
`ifdef BP_RAM_PARITY_EN
   localparam int BW = DATA_WIDTH + 1;
`else
   localparam int BW = DATA_WIDTH;
`endif

   bp_ram_state_t         state;
   logic [AW-1:0]         clear_idx;
   logic                  clearing;
   logic                  rd_accept;
   logic [AW-1:0]         bank_waddr;
   logic [BW-1:0]         bank_wdata;
   logic [NUM_WAYS-1:0]   bypass_sel;
   logic [DATA_WIDTH-1:0] bypass_data;
   logic [NUM_WAYS-1:0]   err_vec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLEAR;
         clear_idx <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clear_idx <= clear_idx + 1'b1;
               if (clear_idx == AW'(DEPTH - 1)) state <= READY;
            end
            READY: begin
               if (clear_req) begin
                  state     <= CLEAR;
                  clear_idx <= '0;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   assign ready     = (state == READY);
   assign clearing  = (state == CLEAR);
   assign rd_accept = ready && read_en;

   // The clear walk owns the write port; external writes only reach the RAM when ready.
   always_comb begin
      bank_waddr = write_addr;
      bank_wdata = '0;
      if (clearing) begin
         bank_waddr = clear_idx;
      end else begin
`ifdef BP_RAM_PARITY_EN
         bank_wdata = {^write_data, write_data};
`else
         bank_wdata = write_data;
`endif
      end
   end

   // Bypass state is captured only with an accepted read so read_data holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_valid  <= 1'b0;
         bypass_sel  <= '0;
         bypass_data <= '0;
      end else begin
         read_valid <= rd_accept;
         if (rd_accept) begin
            bypass_sel  <= (write_en && (write_addr == read_addr)) ? write_way : '0;
            bypass_data <= write_data;
         end
      end
   end

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      logic [BW-1:0] q;

      bp_ram_bank #(
         .WIDTH (BW),
         .DEPTH (DEPTH)
      ) u_bank (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (clearing || (write_en && write_way[w])),
         .waddr (bank_waddr),
         .wdata (bank_wdata),
         .re    (rd_accept),
         .raddr (read_addr),
         .rdata (q)
      );

`ifdef BP_RAM_PARITY_EN
      // A parity error on a stored word is reported as a miss by zeroing the slice.
      assign err_vec[w] = !bypass_sel[w] && (^q);
      assign read_data[w*DATA_WIDTH +: DATA_WIDTH] =
         bypass_sel[w] ? bypass_data : (err_vec[w] ? '0 : q[DATA_WIDTH-1:0]);
`else
      assign err_vec[w] = 1'b0;
      assign read_data[w*DATA_WIDTH +: DATA_WIDTH] = bypass_sel[w] ? bypass_data : q;
`endif
   end

   assign read_parity_err = err_vec;

endmodule

// File: tb/tb_branch_predictor_ram_mw.sv
// Directed self-checking bench for branch_predictor_ram_mw (2 ways, 20-bit entries, depth 512).
module tb_branch_predictor_ram_mw;

   localparam int DW    = 20;
   localparam int DEPTH = 512;
   localparam int NW    = 2;
   localparam int AW    = 9;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           clear_req;
   logic           ready;
   logic [AW-1:0]  write_addr;
   logic           write_en;
   logic [NW-1:0]  write_way;
   logic [DW-1:0]  write_data;
   logic [AW-1:0]  read_addr;
   logic           read_en;
   logic [NW*DW-1:0] read_data;
   logic           read_valid;
   logic [NW-1:0]  read_parity_err;

   int tests_run    = 0;
   int tests_failed = 0;
   int cnt;
   int bad_reads;

   branch_predictor_ram_mw #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .NUM_WAYS   (NW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear_req       (clear_req),
      .ready           (ready),
      .write_addr      (write_addr),
      .write_en        (write_en),
      .write_way       (write_way),
      .write_data      (write_data),
      .read_addr       (read_addr),
      .read_en         (read_en),
      .read_data       (read_data),
      .read_valid      (read_valid),
      .read_parity_err (read_parity_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; returns 1ns after the edge with strobes dropped.
   task automatic applyStimulus(input logic we, input logic [NW-1:0] way, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                                input logic clr);
      write_en   = we;
      write_way  = way;
      write_addr = wa;
      write_data = wd;
      read_en    = re;
      read_addr  = ra;
      clear_req  = clr;
      @(posedge clk);
      #1;
      write_en  = 1'b0;
      read_en   = 1'b0;
      clear_req = 1'b0;
   endtask

   task automatic waitReady(output int cycles);
      cycles = 0;
      while (!ready && cycles < 2000) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_req = 1'b0; write_en = 1'b0; write_way = '0; write_addr = '0;
      write_data = '0; read_en = 1'b0; read_addr = '0;
      #12;
      checkOutput("reset_ready", 64'(ready), 64'd0);
      checkOutput("reset_valid", 64'(read_valid), 64'd0);
      checkOutput("reset_data", 64'(read_data), 64'd0);
      checkOutput("reset_perr", 64'(read_parity_err), 64'd0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;
      cnt = 1;
      if (!ready) begin
         waitReady(bad_reads);
         cnt += bad_reads;
      end
      checkOutput("init_clear_cycles", 64'(cnt), 64'd512);

      bad_reads = 0;
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, AW'(i), 1'b0);
         if (read_data !== '0 || read_valid !== 1'b1) bad_reads++;
      end
      checkOutput("init_all_zero_reads", 64'(bad_reads), 64'd0);

      applyStimulus(1'b1, 2'b10, 9'd5, 20'h12345, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd5, 1'b0);
      checkOutput("wr5_data", 64'(read_data), {24'd0, 20'h12345, 20'h00000});
      checkOutput("wr5_valid", 64'(read_valid), 64'd1);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
      checkOutput("idle_valid", 64'(read_valid), 64'd0);
      checkOutput("idle_hold", 64'(read_data), {24'd0, 20'h12345, 20'h00000});

      applyStimulus(1'b1, 2'b01, 9'd7, 20'hAAAAA, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 2'b10, 9'd7, 20'hBBBBB, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 2'b01, 9'd7, 20'h11111, 1'b1, 9'd7, 1'b0);
      checkOutput("collide_data", 64'(read_data), {24'd0, 20'hBBBBB, 20'h11111});
      applyStimulus(1'b1, 2'b00, 9'd7, 20'h55555, 1'b1, 9'd7, 1'b0);
      checkOutput("ram_after_collide", 64'(read_data), {24'd0, 20'hBBBBB, 20'h11111});
      applyStimulus(1'b1, 2'b11, 9'd8, 20'h0F0F0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd8, 1'b0);
      checkOutput("multihot_data", 64'(read_data), {24'd0, 20'h0F0F0, 20'h0F0F0});

      applyStimulus(1'b1, 2'b11, 9'd3, 20'h33333, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd3, 1'b1);
      checkOutput("flush_same_cycle_read", 64'(read_data), {24'd0, 20'h33333, 20'h33333});
      checkOutput("flush_same_cycle_valid", 64'(read_valid), 64'd1);
      checkOutput("flush_ready_drop", 64'(ready), 64'd0);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd3, 1'b1);
      checkOutput("clear_read_ignored", 64'(read_valid), 64'd0);
      checkOutput("clear_data_hold", 64'(read_data), {24'd0, 20'h33333, 20'h33333});
      applyStimulus(1'b1, 2'b11, 9'd0, 20'h77777, 1'b0, '0, 1'b0);
      cnt = 2;
      waitReady(bad_reads);
      cnt += bad_reads;
      checkOutput("flush_clear_cycles", 64'(cnt), 64'd512);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd3, 1'b0);
      checkOutput("flush_addr3_zero", 64'(read_data), 64'd0);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd0, 1'b0);
      checkOutput("clear_write_ignored", 64'(read_data), 64'd0);

      applyStimulus(1'b1, 2'b11, 9'd8, 20'h0F0F0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd8, 1'b0);
      checkOutput("pre_reset_data", 64'(read_data), {24'd0, 20'h0F0F0, 20'h0F0F0});
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("midclear_reset_data", 64'(read_data), 64'd0);
      checkOutput("midclear_reset_ready", 64'(ready), 64'd0);
      #3 rst_n = 1'b1;
      waitReady(cnt);
      checkOutput("restart_clear_cycles", 64'(cnt), 64'd512);

`ifdef BP_RAM_PARITY_EN
      applyStimulus(1'b1, 2'b11, 9'd9, 20'h00001, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd9, 1'b0);
      checkOutput("parity_clean", 64'(read_parity_err), 64'd0);
      dut.g_way[0].u_bank.mem[9][0] = ~dut.g_way[0].u_bank.mem[9][0];
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd9, 1'b0);
      checkOutput("parity_err", 64'(read_parity_err), 64'd1);
      checkOutput("parity_data", 64'(read_data), {24'd0, 20'h00001, 20'h00000});
`else
      applyStimulus(1'b1, 2'b11, 9'd9, 20'h00001, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 9'd9, 1'b0);
      checkOutput("parity_tied_zero", 64'(read_parity_err), 64'd0);
      checkOutput("addr9_data", 64'(read_data), {24'd0, 20'h00001, 20'h00001});
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
